kgp_trace_buf: RTL

KGP_TRACE_BUF -- requirements
Module: kgp_trace_buf

---
 rtl/kgp_trace_buf.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/kgp_trace_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : kgp_trace_buf                                               |
// | Purpose : Triggered trace buffer. It captures {instruction, routa}    |
// |           pairs into a FIFO. Capture starts on arm, stops POST samples |
// |           after a masked trigger match, and the oldest entry can be   |
// |           popped at any time. MODE selects stop-when-full or          |
// |           circular overwrite.                                         |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module kgp_trace_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int MODE   = 0,
  parameter int POST   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          instruction,
  input  logic [DATA_W-1:0]          routa,
  input  logic                       cap_en,
  input  logic                       arm,
  input  logic                       clr,
  input  logic [DATA_W-1:0]          trig_val,
  input  logic [DATA_W-1:0]          trig_mask,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_instr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [1:0]                 state,
  output logic                       triggered
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    POSTCAP = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            cur_state, nxt_state;
  logic [DATA_W-1:0] mem_instr [DEPTH];
  logic [DATA_W-1:0] mem_data  [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, post_cnt;
  logic [CW-1:0]     cnt;
  logic              capture, trig_hit, pop, is_full;
  logic              do_write, do_overwrite, do_drop;

  // Capture qualification, trigger match and full-buffer handling.
  always_comb begin
    is_full      = (cnt == FULL_CNT);
    capture      = !clr && cap_en && (cur_state == ARMED || cur_state == POSTCAP);
    trig_hit     = capture && (cur_state == ARMED) &&
                   ((instruction & trig_mask) == (trig_val & trig_mask));
    pop          = !clr && rd_req && (cnt != '0);
    // A pop in the same cycle frees a slot, so a full buffer only
    // drops or overwrites when nothing is read out.
    do_write     = capture && (!is_full || pop || (MODE != 0));
    do_overwrite = capture && is_full && !pop && (MODE != 0);
    do_drop      = capture && is_full && !pop && (MODE == 0);
  end

  // Next-state logic for the capture sequencer.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE, DONE: if (arm) nxt_state = ARMED;
      ARMED:      if (trig_hit) nxt_state = (POST == 0) ? DONE : POSTCAP;
      POSTCAP:    if (capture && post_cnt == AW'(1)) nxt_state = DONE;
      default:    nxt_state = IDLE;
    endcase
    if (clr) nxt_state = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_state <= IDLE;
    else        cur_state <= nxt_state;
  end

  // Sample storage; no reset needed since the pointers and count gate reads.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_instr[wr_ptr] <= instruction;
      mem_data[wr_ptr]  <= routa;
    end
  end

  // Pointers, occupancy, sticky flags, post counter and read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      post_cnt  <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
      rd_valid  <= 1'b0;
      rd_instr  <= '0;
      rd_data   <= '0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      post_cnt  <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      // An overwrite discards the oldest entry, same pointer move as a pop.
      if (pop || do_overwrite) rd_ptr <= rd_ptr + 1'b1;
      if (do_write && !pop && !do_overwrite) cnt <= cnt + 1'b1;
      else if (pop && !do_write)             cnt <= cnt - 1'b1;
      if (do_drop || do_overwrite) overflow <= 1'b1;
      if (arm && (cur_state == IDLE || cur_state == DONE)) triggered <= 1'b0;
      else if (trig_hit)                                   triggered <= 1'b1;
      if (trig_hit)                              post_cnt <= AW'(POST);
      else if (cur_state == POSTCAP && capture)  post_cnt <= post_cnt - 1'b1;
      rd_valid <= pop;
      if (pop) begin
        rd_instr <= mem_instr[rd_ptr];
        rd_data  <= mem_data[rd_ptr];
      end
    end
  end

  assign count = cnt;
  assign full  = is_full;
  assign empty = (cnt == '0);
  assign state = cur_state;

endmodule
`default_nettype wire
